// File: rtl/catch_game_ctl.sv
// Game sequencer for the catch-sack game: START/PLAY/END flow, spawn placement,
// catch/miss judgement, score and lives bookkeeping. Single pclk domain.
module catch_game_ctl #(
  parameter int BASKET_Y    = 530,
  parameter int BASKET_W    = 48,
  parameter int OBJ_W       = 48,
  parameter int OBJ_H       = 64,
  parameter int SPAWN_MIN   = 100,
  parameter int SPAWN_RANGE = 600,
  parameter int SPAWN_DELAY = 30,
  parameter int LIVES       = 3,
  parameter int SCORE_MAX   = 9999
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        mouse_left,
  input  logic        mouse_right,
  input  logic [11:0] basket_x,
  input  logic [11:0] obj_x,
  input  logic [11:0] obj_y,
  input  logic        fall_done,
  output logic [1:0]  state_out,
  output logic        fall_on,
  output logic [11:0] spawn_x,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        catch_pulse,
  output logic        miss_pulse
);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_SPAWN = 2'd1;
  localparam logic [1:0] S_FALL  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [1:0] OUT_START = 2'b01;
  localparam logic [1:0] OUT_PLAY  = 2'b11;
  localparam logic [1:0] OUT_END   = 2'b10;

  localparam int CNT_W = $clog2(SPAWN_DELAY + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] frame_cnt;
  logic [15:0]      lfsr;

  logic left_s1, left_s2, left_d, left_click;
  logic right_s1, right_s2, right_d, right_click;
  logic vsync_d, tick;

  // Mouse buttons come from another clock domain: 2-FF sync, then a registered
  // rising-edge detect so a held button yields a single click.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer stages.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      left_s1     <= 1'b0;
      left_s2     <= 1'b0;
      left_d      <= 1'b0;
      left_click  <= 1'b0;
      right_s1    <= 1'b0;
      right_s2    <= 1'b0;
      right_d     <= 1'b0;
      right_click <= 1'b0;
      vsync_d     <= 1'b0;
      tick        <= 1'b0;
      lfsr        <= 16'hACE1;
    end else begin
      left_s1     <= mouse_left;
      left_s2     <= left_s1;
      left_d      <= left_s2;
      left_click  <= left_s2 & ~left_d;
      right_s1    <= mouse_right;
      right_s2    <= right_s1;
      right_d     <= right_s2;
      right_click <= right_s2 & ~right_d;
      vsync_d     <= vsync;
      tick        <= vsync & ~vsync_d;
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  logic [9:0]  off_raw;
  logic [9:0]  off;
  logic [11:0] cand_x;
  logic [12:0] obj_bottom;
  logic        vertical, horizontal, hit;

  // NOTE: every signal driven here gets a value on every path, so no latches.
  always_comb begin
    off_raw    = lfsr[9:0];
    off        = (off_raw > 10'(SPAWN_RANGE)) ? off_raw - 10'(SPAWN_RANGE) - 10'd1 : off_raw;
    cand_x     = 12'(SPAWN_MIN) + {2'b00, off};
    obj_bottom = {1'b0, obj_y} + 13'(OBJ_H);
    vertical   = obj_bottom >= 13'(BASKET_Y);
    horizontal = (({1'b0, obj_x} + 13'(OBJ_W)) > {1'b0, basket_x}) &&
                 (({1'b0, basket_x} + 13'(BASKET_W)) > {1'b0, obj_x});
    hit        = vertical && horizontal;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state       <= S_START;
      state_out   <= OUT_START;
      fall_on     <= 1'b0;
      spawn_x     <= 12'd400;
      score       <= 16'd0;
      lives       <= 2'(LIVES);
      catch_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      catch_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      case (state)
        S_START: begin
          score <= 16'd0;
          lives <= 2'(LIVES);
          if (left_click) begin
            spawn_x   <= cand_x;
            frame_cnt <= '0;
            state     <= S_SPAWN;
            state_out <= OUT_PLAY;
          end
        end
        S_SPAWN: begin
          if (tick) begin
            if (frame_cnt == CNT_W'(SPAWN_DELAY - 1)) begin
              state   <= S_FALL;
              fall_on <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        S_FALL: begin
          if (fall_done) begin
            fall_on <= 1'b0;
            if (hit) begin
              catch_pulse <= 1'b1;
              if (score < 16'(SCORE_MAX)) score <= score + 16'd1;
              spawn_x   <= cand_x;
              frame_cnt <= '0;
              state     <= S_SPAWN;
            end else begin
              miss_pulse <= 1'b1;
              lives      <= lives - 2'd1;
              if (lives == 2'd1) begin
                state     <= S_OVER;
                state_out <= OUT_END;
              end else begin
                spawn_x   <= cand_x;
                frame_cnt <= '0;
                state     <= S_SPAWN;
              end
            end
          end
        end
        default: begin
          if (right_click) begin
            score     <= 16'd0;
            lives     <= 2'(LIVES);
            state     <= S_START;
            state_out <= OUT_START;
          end
        end
      endcase
    end
  end

endmodule
